// File: rtl/cb_cfg_loader_if.sv
// Configuration stream and committed-image bus between the tile configuration
// controller (master) and one connection-block loader (slave).
//   start    : master -> slave, one-cycle pulse that begins/restarts a load
//   in_data  : master -> slave, configuration word
//   in_valid : master -> slave, in_data is valid
//   in_ready : slave -> master, loader accepts a word this cycle
//   cfg      : slave -> master/fabric, committed configuration image
//   busy     : slave -> master, loader is not idle
//   done     : slave -> master, one-cycle pulse when a new cfg is visible
interface cb_cfg_loader_if #(
    parameter int unsigned CFG_SIZE   = 256,
    parameter int unsigned WORD_WIDTH = 32
);
    logic                  start;
    logic [WORD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [CFG_SIZE-1:0]   cfg;
    logic                  busy;
    logic                  done;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, cfg, busy, done
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, cfg, busy, done
    );
endinterface

// File: rtl/cb_cfg_loader.sv
// Connection-block configuration loader. Assembles a word-serial image into a
// shadow register and commits it to cfg in a single cycle so the mux selects
// never observe a partially loaded image.
//   clk   : clock for all state
//   rst_n : asynchronous active-low reset (cfg returns to all-zero, safe selects)
//   bus   : cb_cfg_loader_if slave modport (start/in_data/in_valid/in_ready,
//           cfg/busy/done); all outputs are registered
module cb_cfg_loader #(
    parameter int unsigned CFG_SIZE   = 256,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    cb_cfg_loader_if.slave   bus
);

    localparam int unsigned NWORDS   = (CFG_SIZE + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int unsigned CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned SHADOW_W = NWORDS * WORD_WIDTH;
    localparam logic [SHADOW_W-1:0] WORD_MASK = SHADOW_W'({WORD_WIDTH{1'b1}});
    localparam logic [CNT_W-1:0]    LAST_CNT  = CNT_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_SIZE-1:0] shadow_q, shadow_d;
    logic [CFG_SIZE-1:0] cfg_q, cfg_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [31:0]         word_sh;

    // Bit offset of the word slot currently being filled.
    assign word_sh = WORD_WIDTH * 32'(cnt_q);

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        cfg_d    = cfg_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_LOAD;
                    cnt_d    = '0;
                    shadow_d = '0;
                end
            end
            S_LOAD: begin
                // start beats a simultaneous word; that word is dropped.
                if (bus.start) begin
                    cnt_d    = '0;
                    shadow_d = '0;
                end else if (bus.in_valid && in_ready_q) begin
                    // Slot is widened to the padded image then truncated, so
                    // last-word bits at or above CFG_SIZE fall away.
                    shadow_d = (shadow_q & ~CFG_SIZE'(WORD_MASK << word_sh))
                             | CFG_SIZE'(SHADOW_W'(bus.in_data) << word_sh);
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                cfg_d   = shadow_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake/status flags are registered copies of the next state.
        in_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d != S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shadow_q   <= '0;
            cfg_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            cfg_q      <= cfg_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.cfg      = cfg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_cb_cfg_loader.sv
// Self-checking bench for cb_cfg_loader: directed scenarios plus randomized
// traffic compared against a word-queue reference model.
module tb_cb_cfg_loader;

    localparam int unsigned NW = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cb_cfg_loader_if #(.CFG_SIZE(256), .WORD_WIDTH(32)) b  ();
    cb_cfg_loader_if #(.CFG_SIZE(200), .WORD_WIDTH(32)) bo ();

    cb_cfg_loader #(.CFG_SIZE(256), .WORD_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    cb_cfg_loader #(.CFG_SIZE(200), .WORD_WIDTH(32)) dut_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bo)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt = 0;
    int done_cnt = 0;

    // Reference model: phase 0 idle, 1 collecting words, 2 commit pending.
    int           m_phase;
    logic [31:0]  m_words[$];
    logic [255:0] m_cfg;
    bit           m_done;

    function automatic logic [255:0] m_image();
        logic [255:0] img = '0;
        for (int i = 0; i < m_words.size(); i++) img[i*32 +: 32] = m_words[i];
        return img;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_words.delete();
        m_cfg   = '0;
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input bit s, input bit v, input logic [31:0] d);
        m_done = 1'b0;
        if (m_phase == 2) begin
            m_cfg   = m_image();
            m_done  = 1'b1;
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (s) m_words.delete();
            else if (v) begin
                m_words.push_back(d);
                if (m_words.size() == NW) m_phase = 2;
            end
        end else if (s) begin
            m_phase = 1;
            m_words.delete();
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("cfg",      b.cfg,             m_cfg);
        chk("in_ready", 256'(b.in_ready),  256'(m_phase == 1));
        chk("busy",     256'(b.busy),      256'(m_phase != 0));
        chk("done",     256'(b.done),      256'(m_done));
    endtask

    // One clock of the main instance: drive, clock, step model, check.
    task automatic cyc(input bit s, input bit v, input logic [31:0] d);
        b.start    = s;
        b.in_valid = v;
        b.in_data  = d;
        @(posedge clk);
        model_edge(s, v, d);
        #1;
        if (b.in_ready === 1'b1) rdy_cnt++;
        if (b.done === 1'b1) done_cnt++;
        check_model();
    endtask

    task automatic ocyc(input bit s, input bit v, input logic [31:0] d);
        bo.start    = s;
        bo.in_valid = v;
        bo.in_data  = d;
        @(posedge clk);
        #1;
        if (bo.in_ready === 1'b1) rdy_cnt++;
    endtask

    task automatic load_image(input logic [31:0] w);
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) cyc(1'b0, 1'b1, w);
        cyc(1'b0, 1'b0, '0);
    endtask

    initial begin
        int idx;
        bit v;
        logic [31:0] w;

        rst_n = 1'b1;
        b.start = 1'b0;  b.in_valid = 1'b0;  b.in_data = '0;
        bo.start = 1'b0; bo.in_valid = 1'b0; bo.in_data = '0;

        // Reset asserted mid-cycle; outputs must clear without a clock.
        #13 rst_n = 1'b0;
        #1;
        chk("rst_cfg",      b.cfg,            '0);
        chk("rst_in_ready", 256'(b.in_ready), '0);
        chk("rst_busy",     256'(b.busy),     '0);
        chk("rst_done",     256'(b.done),     '0);
        chk("rst_odd_cfg",  256'(bo.cfg),     '0);
        model_reset();
        #9 rst_n = 1'b1;

        // Full load at maximum throughput.
        rdy_cnt = 0; done_cnt = 0;
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) cyc(1'b0, 1'b1, 32'(32'h1111_1111 * (i + 1)));
        cyc(1'b0, 1'b0, '0);
        chk("full_lo_word", 256'(b.cfg[31:0]),    256'(32'h1111_1111));
        chk("full_hi_word", 256'(b.cfg[255:224]), 256'(32'h8888_8888));
        chk("full_done",    256'(b.done),         256'(1'b1));
        chk("full_ready_cycles", 256'(rdy_cnt),   256'(8));
        cyc(1'b0, 1'b0, '0);
        chk("full_done_pulses", 256'(done_cnt),   256'(1));

        // Backpressure over a prior all-ones image.
        load_image(32'hFFFF_FFFF);
        chk("ones_image", b.cfg, {256{1'b1}});
        cyc(1'b1, 1'b0, '0);
        idx = 0;
        for (int t = 0; t < 200 && idx < NW; t++) begin
            v = 1'($urandom_range(0, 1));
            w = v ? 32'(32'h1111_1111 * (idx + 1)) : $urandom;
            cyc(1'b0, v, w);
            if (v) idx++;
        end
        chk("bp_words_sent", 256'(idx), 256'(NW));
        chk("bp_cfg_held", b.cfg, {256{1'b1}});
        cyc(1'b0, 1'b0, '0);
        chk("bp_image", b.cfg,
            256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);

        // Abort: restart pulsed together with a fourth word.
        done_cnt = 0;
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'hDEAD_BEEF);
        cyc(1'b1, 1'b1, 32'hDEAD_BEEF);
        for (int i = 0; i < NW; i++) cyc(1'b0, 1'b1, 32'(i));
        cyc(1'b0, 1'b0, '0);
        chk("abort_image", b.cfg,
            256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
        cyc(1'b0, 1'b0, '0);
        chk("abort_done_pulses", 256'(done_cnt), 256'(1));

        // start during the commit cycle is ignored.
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) cyc(1'b0, 1'b1, 32'hC0DE_0000 | 32'(i));
        cyc(1'b1, 1'b0, '0);
        chk("commit_start_busy", 256'(b.busy), '0);
        cyc(1'b0, 1'b0, '0);

        // Randomized traffic against the model.
        for (int t = 0; t < 400; t++) begin
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0), $urandom);
        end
        for (int t = 0; t < 12; t++) cyc(1'b0, 1'b0, '0);

        // Reset in the middle of a load.
        load_image(32'hA5A5_A5A5);
        chk("a5_image", b.cfg, {32{8'hA5}});
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, $urandom);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_cfg",      b.cfg,            '0);
        chk("midrst_busy",     256'(b.busy),     '0);
        chk("midrst_in_ready", 256'(b.in_ready), '0);
        model_reset();
        #2 rst_n = 1'b1;
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < NW; i++) cyc(1'b0, 1'b1, $urandom);
        cyc(1'b0, 1'b0, '0);
        chk("post_rst_done", 256'(b.done), 256'(1'b1));
        b.start = 1'b0; b.in_valid = 1'b0;

        // Odd size: 200-bit image, 7 words, top 24 bits of the last word dropped.
        rdy_cnt = 0;
        ocyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 7; i++) ocyc(1'b0, 1'b1, 32'hFFFF_FFFF);
        chk("odd_cfg_before", 256'(bo.cfg), '0);
        chk("odd_commit_busy", 256'(bo.busy), 256'(1'b1));
        ocyc(1'b0, 1'b0, '0);
        chk("odd_ready_cycles", 256'(rdy_cnt), 256'(7));
        chk("odd_cfg", 256'(bo.cfg), {56'h0, {200{1'b1}}});
        chk("odd_done", 256'(bo.done), 256'(1'b1));
        chk("odd_busy", 256'(bo.busy), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cb_cfg_loader.md
# cb_cfg_loader

Configuration writer for the connection-block mux select bus. It accepts a word-serial configuration stream over a valid/ready handshake and assembles the words in a shadow register. Once the final word is in, it commits the whole image to the `cfg` output in a single cycle, so the connection block's mux selects never see a partially loaded image. One instance sits beside each connection block in the tile. It is driven by the tile's configuration controller.

## Interface

Parameters:
- `CFG_SIZE`, 256, width of the `cfg` bus driven into the connection block.
- `WORD_WIDTH`, 32, width of one configuration stream word.
- `NWORDS` (localparam), ceil(`CFG_SIZE`/`WORD_WIDTH`), number of words per image.
- `CNT_W` (localparam), max(1, $clog2(`NWORDS`)), width of the word counter.

Ports:
- `clk`  input  1  single clock for all state.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  one-cycle pulse that begins (or restarts) an image load.
- `in_data`  input  `WORD_WIDTH`  configuration word.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a word this cycle.
- `cfg`  output  `CFG_SIZE`  committed configuration image, registered.
- `busy`  output  1  high whenever the state is not IDLE.
- `done`  output  1  one-cycle pulse that is high in the first cycle a new `cfg` is visible.

## Operation

- States are IDLE, LOAD and COMMIT.
- Reset (async, `rst_n` low) forces: state IDLE, counter 0, shadow 0, `cfg` 0, `in_ready` 0, `busy` 0, `done` 0.
  - All-zero `cfg` selects mux input 0, the constant-0 input, so fabric outputs are safe after reset.
- IDLE:
  - `in_ready` is 0.
  - `start` moves to LOAD, clears the counter and clears the shadow.
- LOAD:
  - `in_ready` is 1.
  - A word is accepted when `in_valid` and `in_ready` are both high. On accept: shadow[cnt*`WORD_WIDTH` +: `WORD_WIDTH`] <= `in_data`, then cnt increments.
  - Word 0 maps to `cfg[WORD_WIDTH-1:0]` (LSB word first).
  - For the last word, bits at or above `CFG_SIZE` are discarded.
  - Accepting word cnt == `NWORDS`-1 moves to COMMIT.
- COMMIT:
  - Lasts one cycle, with `in_ready` 0.
  - At the edge leaving COMMIT: `cfg` <= shadow, `done` <= 1, next state IDLE.
- `done` deasserts on the following edge unless another commit occurs; back-to-back commits are impossible.
- `start` in LOAD aborts the load: counter back to 0, shadow cleared, `cfg` untouched, state stays LOAD.
- `start` in the same cycle as an otherwise-accepted word: `start` wins and the word is discarded.
  - `in_ready` is still 1 that cycle, so the upstream sees a handshake; the upstream must resend the full image after any `start`.
- `start` in COMMIT is ignored; the commit completes.
- `cfg` changes only at the COMMIT exit edge or on reset. It is stable throughout LOAD.

## Timing

- `start` sampled at edge k: `in_ready` and `busy` are high from cycle k+1.
- Maximum throughput is one word per cycle.
  - With `in_valid` held high, the last word is accepted at edge k+`NWORDS`.
  - COMMIT occupies the next cycle.
  - `cfg`/`done` are visible after edge k+`NWORDS`+1, and `busy` is low from that same cycle.
- Load-to-commit latency after the last accepted word is 1 cycle.
- `in_ready` depends only on state. There is no combinational path from `in_valid` to `in_ready`.
- Reset mid-operation takes effect immediately (asynchronous): the partial image is lost and `cfg` returns to 0.

## Test plan

- Reset check: assert `rst_n`=0 mid-cycle, then release. Required: `cfg`=0, `in_ready`=0, `busy`=0, `done`=0 immediately on reset assertion.
- Full load, default parameters (`NWORDS`=8):
  - Stimulus: `start`, then words 0x11111111*(i+1) for i=0..7 with `in_valid` held high.
  - Required: `in_ready` high for exactly 8 cycles; `cfg[31:0]`=0x11111111 and `cfg[255:224]`=0x88888888 after edge start+9; `done` high for that one cycle.
- Backpressure:
  - Stimulus: same 8 words with random `in_valid` gaps, after a prior image of all-ones.
  - Required: `cfg` stays all-ones until commit, then equals the new image exactly.
- Abort:
  - Stimulus: `start`, 3 words of 0xDEADBEEF, `start` again (pulsed together with a 4th word), then 8 words of 0x0000000i (i=0..7).
  - Required: `cfg` equals the second image only, and `done` pulses once.
- Odd size:
  - Stimulus: `CFG_SIZE`=200, `WORD_WIDTH`=32, 7 words of 0xFFFFFFFF.
  - Required: `NWORDS`=7 and `cfg`=all-ones (200 bits); upper 24 bits of word 6 dropped without error.
- Reset mid-load:
  - Stimulus: a committed image of 0xA5 bytes, then 4 words of a new load, then `rst_n` low.
  - Required: `cfg`=0 and state IDLE. A subsequent `start` with 8 words loads cleanly.
